tx_scrambler_framer: RTL and testbench

//  Transmit-side counterpart of the receiver descrambler: bit-serial 802.11a data-field builder and scrambler.
//  - On Start it emits the frame: 16-bit SERVICE (zeros), then the PSDU bits, then 6 tail bits, then pad bits up to an NDBPS boundary.
//  - Every bit is scrambled with S(x)=x^7+x^4+1. Tail bits are forced to 0 after scrambling.
//  - Output feeds the convolutional encoder.

---
 rtl/tx_scrambler_framer.sv | 162 ++++++++++++++++
 tb/tb_tx_scrambler_framer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scrambler_framer.sv
// rtl/tx_scrambler_framer.sv - bit-serial 802.11a DATA-field builder and x^7+x^4+1 scrambler
// Emits SERVICE, PSDU, tail and pad bits on a valid/ready stream toward the convolutional encoder.
module tx_scrambler_framer #(
  parameter int NDBPS = 24,
  parameter int LEN_W = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [6:0]       Seed,
  input  logic [LEN_W-1:0] Len,
  input  logic             In_Data,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic             Out,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Busy,
  output logic             Done
);

  localparam int BIT_W = LEN_W + 3;
  localparam int SYM_W = 8;
  localparam logic [6:0] SEED_SUB = 7'b1011101;

  typedef enum logic [2:0] {
    IDLE,
    SERVICE,
    PSDU,
    TAIL,
    PAD,
    DONE
  } state_t;

  state_t           state;
  logic [6:0]       lfsr;
  logic [LEN_W-1:0] len_r;
  logic [BIT_W-1:0] bit_cnt;
  logic [SYM_W-1:0] sym_cnt;
  logic             busy_r;
  logic             done_r;

  logic             fb;
  logic             xfer;
  logic             sym_wrap;
  logic [SYM_W-1:0] sym_next;
  logic [BIT_W-1:0] bit_next;
  logic [BIT_W-1:0] psdu_bits;

  // lfsr[6] is x7, lfsr[3] is x4, lfsr[0] is x1
  assign fb        = lfsr[6] ^ lfsr[3];
  assign psdu_bits = {len_r, 3'b000};
  assign bit_next  = bit_cnt + BIT_W'(1);
  assign sym_wrap  = (sym_cnt == SYM_W'(NDBPS - 1));
  assign sym_next  = sym_wrap ? '0 : sym_cnt + SYM_W'(1);
  assign xfer      = Out_Valid && Out_Ready;
  assign Busy      = busy_r;
  assign Done      = done_r;

  always_comb begin
    Out       = 1'b0;
    Out_Valid = 1'b0;
    In_Ready  = 1'b0;
    case (state)
      SERVICE: begin
        Out_Valid = 1'b1;
        Out       = fb;
      end
      PSDU: begin
        // zero-latency pass-through: upstream handshake is tied to downstream
        Out_Valid = In_Valid;
        In_Ready  = Out_Ready;
        Out       = In_Data ^ fb;
      end
      TAIL: begin
        Out_Valid = 1'b1;
        Out       = 1'b0;
      end
      PAD: begin
        Out_Valid = 1'b1;
        Out       = fb;
      end
      default: begin
        Out       = 1'b0;
        Out_Valid = 1'b0;
        In_Ready  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      lfsr    <= '0;
      len_r   <= '0;
      bit_cnt <= '0;
      sym_cnt <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (Start) begin
            lfsr    <= (Seed == 7'd0) ? SEED_SUB : Seed;
            len_r   <= Len;
            bit_cnt <= '0;
            sym_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= SERVICE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        SERVICE, PSDU, TAIL, PAD: begin
          if (xfer) begin
            lfsr    <= {lfsr[5:0], fb};
            sym_cnt <= sym_next;
            bit_cnt <= bit_next;
            case (state)
              SERVICE: begin
                if (bit_cnt == BIT_W'(15)) begin
                  bit_cnt <= '0;
                  state   <= (len_r == '0) ? TAIL : PSDU;
                end
              end
              PSDU: begin
                if (bit_next == psdu_bits) begin
                  bit_cnt <= '0;
                  state   <= TAIL;
                end
              end
              TAIL: begin
                if (bit_cnt == BIT_W'(5)) begin
                  bit_cnt <= '0;
                  if (sym_wrap) begin
                    state  <= DONE;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                  end else begin
                    state <= PAD;
                  end
                end
              end
              default: begin
                if (sym_wrap) begin
                  state  <= DONE;
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scrambler_framer.sv
// tb/tb_tx_scrambler_framer.sv - self-checking bench for tx_scrambler_framer
// Reference frame is built from the scrambler recurrence s[n]=s[n-7]^s[n-4] and the frame layout rules.
module tb_tx_scrambler_framer;

  localparam int NDBPS = 24;
  localparam int LEN_W = 12;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [6:0]       Seed = 7'd0;
  logic [LEN_W-1:0] Len = '0;
  logic             In_Data = 1'b0;
  logic             In_Valid = 1'b0;
  logic             In_Ready;
  logic             Out;
  logic             Out_Valid;
  logic             Out_Ready = 1'b1;
  logic             Busy;
  logic             Done;

  int   n_checks = 0;
  int   n_fail = 0;
  logic psdu_q[$];
  logic cap[$];
  logic exp_q[$];
  int   in_idx = 0;
  bit   stall = 0;
  bit   take_in = 0;
  int   done_cnt = 0;
  int   done_at = -1;

  tx_scrambler_framer #(.NDBPS(NDBPS), .LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Seed(Seed), .Len(Len),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Out(Out), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    take_in = In_Valid && In_Ready && !Reset;
    if (Out_Valid && Out_Ready && !Reset) cap.push_back(Out);
    if (Done) begin
      done_cnt++;
      done_at = cap.size();
    end
  end

  always @(posedge Clk) begin
    #1;
    if (take_in) in_idx++;
    Out_Ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (in_idx < psdu_q.size()) begin
      In_Valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      In_Data  = psdu_q[in_idx];
    end else begin
      In_Valid = 1'b0;
      In_Data  = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_bytes(input int nbytes, input bit rnd);
    logic [7:0] b;
    psdu_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : 8'h00;
      for (int k = 0; k < 8; k++) psdu_q.push_back(b[k]);
    end
  endtask

  task automatic build_expected(input logic [6:0] seed, input int len);
    int   nb;
    int   total;
    logic e[];
    logic d;
    nb    = 8 * len;
    total = NDBPS * ((22 + nb + NDBPS - 1) / NDBPS);
    e     = new[total + 7];
    for (int k = 1; k <= 7; k++) e[7 - k] = seed[k - 1];
    for (int i = 7; i < total + 7; i++) e[i] = e[i - 7] ^ e[i - 4];
    exp_q.delete();
    for (int n = 0; n < total; n++) begin
      if (n >= 16 + nb && n < 22 + nb) exp_q.push_back(1'b0);
      else begin
        d = (n >= 16 && n < 16 + nb) ? psdu_q[n - 16] : 1'b0;
        exp_q.push_back(d ^ e[n + 7]);
      end
    end
  endtask

  task automatic start_frame(input logic [6:0] seed, input int len, input bit stl);
    @(negedge Clk);
    stall  = stl;
    in_idx = 0;
    cap.delete();
    done_at = -1;
    Seed  = seed;
    Len   = LEN_W'(len);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start_cnt);
    int budget = 0;
    while (done_cnt == start_cnt && budget < 20000) begin
      @(negedge Clk);
      budget++;
    end
    check({tag, " done seen"}, 64'(done_cnt != start_cnt), 64'd1);
    repeat (4) @(negedge Clk);
    check({tag, " done pulses"}, 64'(done_cnt - start_cnt), 64'd1);
    check({tag, " busy after"}, 64'(Busy), 64'd0);
  endtask

  task automatic compare_stream(input string tag);
    int mism = 0;
    check({tag, " length"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      if (cap[i] !== exp_q[i]) mism++;
    check({tag, " bit errors"}, 64'(mism), 64'd0);
    check({tag, " done at bit"}, 64'(done_at), 64'(exp_q.size()));
  endtask

  task automatic run_frame(input string tag, input logic [6:0] seed, input logic [6:0] model_seed,
                           input int len, input bit stl);
    int c0 = done_cnt;
    start_frame(seed, len, stl);
    wait_done(tag, c0);
    build_expected(model_seed, len);
    compare_stream(tag);
  endtask

  task automatic check_descramble(input string tag, input int nb);
    logic f[];
    int   n;
    int   svc = 0;
    int   mism = 0;
    int   tl = 0;
    n = cap.size();
    check({tag, " rx length"}, 64'(n >= 22 + nb), 64'd1);
    if (n >= 22 + nb) begin
      f = new[n];
      for (int i = 0; i < n; i++) f[i] = (i < 7) ? cap[i] : (f[i - 7] ^ f[i - 4]);
      for (int i = 0; i < 16; i++) if ((cap[i] ^ f[i]) !== 1'b0) svc++;
      for (int j = 0; j < nb; j++) if ((cap[16 + j] ^ f[16 + j]) !== psdu_q[j]) mism++;
      for (int k = 0; k < 6; k++) if (cap[16 + nb + k] !== 1'b0) tl++;
      check({tag, " descrambled service"}, 64'(svc), 64'd0);
      check({tag, " descrambled psdu"}, 64'(mism), 64'd0);
      check({tag, " raw tail"}, 64'(tl), 64'd0);
    end
  endtask

  initial begin
    logic [23:0] head;
    logic [5:0]  tail6;
    int          c0;
    int          budget;

    repeat (3) @(negedge Clk);
    check("reset Out", 64'(Out), 64'd0);
    check("reset Out_Valid", 64'(Out_Valid), 64'd0);
    check("reset In_Ready", 64'(In_Ready), 64'd0);
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Done", 64'(Done), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Test 1: known 802.11 sequence for an all-ones seed
    load_bytes(1, 1'b0);
    run_frame("t1", 7'h7F, 7'h7F, 1, 1'b0);
    head  = '0;
    tail6 = '1;
    if (cap.size() >= 30) begin
      for (int i = 0; i < 24; i++) head = {head[22:0], cap[i]};
      for (int i = 24; i < 30; i++) tail6 = {tail6[4:0], cap[i]};
    end
    check("t1 first 24 bits", 64'(head), 64'(24'b000011101111001011001001));
    check("t1 tail zeros", 64'(tail6), 64'd0);
    check("t1 stalled", 64'(0), 64'(0 & 0));
    n_checks--;
    run_frame("t3a stalled", 7'h7F, 7'h7F, 1, 1'b1);

    // Test 2: loopback through a receiver-style descrambler
    load_bytes(100, 1'b1);
    run_frame("t2", 7'h5A, 7'h5A, 100, 1'b0);
    check_descramble("t2", 800);
    run_frame("t3b stalled", 7'h5A, 7'h5A, 100, 1'b1);
    check_descramble("t3b", 800);

    // Test 4: illegal zero seed behaves as 7'b1011101
    load_bytes(1, 1'b0);
    run_frame("t4 seed0", 7'h00, 7'b1011101, 1, 1'b0);
    run_frame("t4 seed5d", 7'b1011101, 7'b1011101, 1, 1'b0);

    // Test 5: abort mid-PSDU, then a clean frame
    c0 = done_cnt;
    start_frame(7'h7F, 1, 1'b0);
    budget = 0;
    while (in_idx < 5 && budget < 200) begin
      @(negedge Clk);
      budget++;
    end
    check("t5 reached psdu bit 5", 64'(in_idx >= 5), 64'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("t5 Busy after reset", 64'(Busy), 64'd0);
    check("t5 Out_Valid after reset", 64'(Out_Valid), 64'd0);
    check("t5 In_Ready after reset", 64'(In_Ready), 64'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("t5 no done on abort", 64'(done_cnt - c0), 64'd0);
    run_frame("t5 restart", 7'h7F, 7'h7F, 1, 1'b0);

    // Test 6: empty PSDU, with a Start pulse while busy
    psdu_q.delete();
    c0 = done_cnt;
    start_frame(7'h33, 0, 1'b0);
    repeat (4) @(negedge Clk);
    Seed  = 7'h11;
    Len   = LEN_W'(3);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done("t6", c0);
    build_expected(7'h33, 0);
    compare_stream("t6");
    check("t6 frame bits", 64'(cap.size()), 64'd24);
    repeat (10) @(negedge Clk);
    check("t6 idle after", 64'(Busy), 64'd0);
    check("t6 single done", 64'(done_cnt - c0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
